// File: rtl/ymux_arb.sv
// ymux_arb: N-channel to one-output mux/arbiter with a single registered
// output slot. Fixed-select mode is always present. Defining the macro
// YMUX_ARB_RR_EN adds a round-robin mode (selected by the mode input)
// together with its rotating priority pointer.
module ymux_arb #(
  parameter int SIZE = 32,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*SIZE-1:0] in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  output logic [SIZE-1:0]   out_data,
  output logic [SELW-1:0]   out_chan,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SIZE-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic            out_valid_q, out_valid_d;

  logic            can_accept;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [SIZE-1:0] grant_data;
  logic            xfer;

`ifdef YMUX_ARB_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
`else
  // Without round-robin support the mode input has no effect.
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // The output slot can take a word when empty or when it is being drained.
  assign can_accept = !out_valid_q || out_ready;
  // Reset blocks every handshake, so nothing is accepted while it is held.
  assign xfer       = grant_vld && can_accept && !reset;

  // Pick the granted channel: fixed sel, or a round-robin scan from ptr.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i) && in_valid[i]) begin
        grant_vld  = 1'b1;
        grant_idx  = SELW'(i);
        grant_data = in_data[i*SIZE +: SIZE];
      end
    end
`ifdef YMUX_ARB_RR_EN
    if (mode) begin
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_data = '0;
      // Channels at or above ptr first, then wrap to the ones below it.
      for (int i = 0; i < N; i++) begin
        if (!grant_vld && in_valid[i] && SELW'(i) >= ptr_q) begin
          grant_vld  = 1'b1;
          grant_idx  = SELW'(i);
          grant_data = in_data[i*SIZE +: SIZE];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!grant_vld && in_valid[i] && SELW'(i) < ptr_q) begin
          grant_vld  = 1'b1;
          grant_idx  = SELW'(i);
          grant_data = in_data[i*SIZE +: SIZE];
        end
      end
    end
`endif
  end

  // Ready goes only to the granted channel, and only when a transfer happens.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant_idx == SELW'(i));
    end
  end

  // Next output slot: load on transfer, clear on a pop with nothing new.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef YMUX_ARB_RR_EN
  // Advance the pointer past the winner, only on round-robin transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode) begin
      ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Output slot registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_ymux_arb.sv
// tb_ymux_arb: drives a 32-bit/4-channel and an 8-bit/3-channel ymux_arb.
// A negedge monitor models grant, ready and pointer for each instance and
// keeps a queue of expected output words, compared as they are presented.
module tb_ymux_arb;

`ifdef YMUX_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  c;
  } word_t;

  logic clk = 1'b0;
  logic reset;

  logic [127:0] d0_in_data;
  logic [3:0]   d0_in_valid, d0_in_ready;
  logic [1:0]   d0_sel, d0_out_chan;
  logic         d0_mode, d0_out_valid, d0_out_ready;
  logic [31:0]  d0_out_data;

  logic [23:0]  d1_in_data;
  logic [2:0]   d1_in_valid, d1_in_ready;
  logic [1:0]   d1_sel, d1_out_chan;
  logic         d1_mode, d1_out_valid, d1_out_ready;
  logic [7:0]   d1_out_data;

  int n_checks = 0;
  int n_errors = 0;
  word_t sb0[$];
  word_t sb1[$];
  int ptr_m[2];

  always #5 clk = ~clk;

  ymux_arb #(.SIZE(32), .N(4), .SELW(2)) u0 (
    .clk(clk), .reset(reset), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .mode(d0_mode), .out_data(d0_out_data),
    .out_chan(d0_out_chan), .out_valid(d0_out_valid), .out_ready(d0_out_ready)
  );

  ymux_arb #(.SIZE(8), .N(3), .SELW(2)) u1 (
    .clk(clk), .reset(reset), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .mode(d1_mode), .out_data(d1_out_data),
    .out_chan(d1_out_chan), .out_valid(d1_out_valid), .out_ready(d1_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference arbitration: fixed select or ascending scan from pointer p.
  function automatic void model_grant(input int n, input logic [15:0] v, input int s,
                                      input logic rr, input int p,
                                      output logic gv, output int gi);
    gv = 1'b0;
    gi = 0;
    if (rr) begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (p + k) % n;
        if (!gv && v[c]) begin
          gv = 1'b1;
          gi = c;
        end
      end
    end else if (s < n && v[s]) begin
      gv = 1'b1;
      gi = s;
    end
  endfunction

  task automatic mon(input int id);
    int n, s, oc, gi, sz;
    logic [15:0] v, rdy, exp_rdy;
    logic m, ov, ordy, gv, can, rr;
    logic [31:0] od;
    logic [31:0] din[4];
    word_t w, nw;
    w = '0;
    if (id == 0) begin
      n = 4; v = {12'b0, d0_in_valid}; rdy = {12'b0, d0_in_ready};
      s = int'(d0_sel); m = d0_mode; ov = d0_out_valid; ordy = d0_out_ready;
      od = d0_out_data; oc = int'(d0_out_chan);
      for (int i = 0; i < 4; i++) din[i] = d0_in_data[i*32 +: 32];
      sz = sb0.size();
      if (sz != 0) w = sb0[0];
    end else begin
      n = 3; v = {13'b0, d1_in_valid}; rdy = {13'b0, d1_in_ready};
      s = int'(d1_sel); m = d1_mode; ov = d1_out_valid; ordy = d1_out_ready;
      od = {24'b0, d1_out_data}; oc = int'(d1_out_chan);
      for (int i = 0; i < 3; i++) din[i] = {24'b0, d1_in_data[i*8 +: 8]};
      din[3] = '0;
      sz = sb1.size();
      if (sz != 0) w = sb1[0];
    end
    if (reset) begin
      check($sformatf("u%0d.rst_in_ready", id), rdy, 0);
      check($sformatf("u%0d.rst_out_valid", id), ov, 0);
      if (id == 0) sb0.delete(); else sb1.delete();
      ptr_m[id] = 0;
      return;
    end
    check($sformatf("u%0d.out_valid", id), ov, sz != 0);
    if (sz != 0) begin
      check($sformatf("u%0d.out_data", id), od, w.d);
      check($sformatf("u%0d.out_chan", id), oc, w.c);
    end
    can = (sz == 0) || ordy;
    if (sz != 0 && ordy) begin
      if (id == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    end
    rr = RR_EN && m;
    model_grant(n, v, s, rr, ptr_m[id], gv, gi);
    exp_rdy = (gv && can) ? (16'(1) << gi) : 16'(0);
    check($sformatf("u%0d.in_ready", id), rdy, exp_rdy);
    if (gv && can) begin
      nw.d = din[gi];
      nw.c = 2'(gi);
      if (id == 0) sb0.push_back(nw); else sb1.push_back(nw);
      if (rr) ptr_m[id] = (gi + 1) % n;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    logic [31:0] x_word;
    reset = 1'b1;
    d0_in_data = '0; d0_in_valid = 4'hF; d0_sel = 2'd0; d0_mode = 1'b0; d0_out_ready = 1'b1;
    d1_in_data = '0; d1_in_valid = '0;   d1_sel = 2'd0; d1_mode = 1'b0; d1_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", d0_out_valid, 0);
    check("rst.out_data", d0_out_data, 0);
    check("rst.out_chan", d0_out_chan, 0);
    check("rst.in_ready", d0_in_ready, 0);

    // First transfer on the first edge after reset release.
    reset = 1'b0;
    d0_in_data[31:0] = 32'h1111_2222;
    cyc(1);
    check("first.out_valid", d0_out_valid, 1);
    check("first.out_chan", d0_out_chan, 0);
    check("first.out_data", d0_out_data, 32'h1111_2222);

    // Fixed select of channel 2.
    d0_in_valid = 4'b0100; d0_sel = 2'd2; d0_in_data[64 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("fix2.in_ready", d0_in_ready, 4'b0100);
    cyc(1);
    check("fix2.out_valid", d0_out_valid, 1);
    check("fix2.out_data", d0_out_data, 32'hDEAD_BEEF);
    check("fix2.out_chan", d0_out_chan, 2);

    // Selected channel not valid: nothing granted, slot drains.
    d0_in_valid = 4'b0001; d0_sel = 2'd1;
    #1;
    check("fix1.in_ready", d0_in_ready, 4'b0000);
    cyc(1);
    check("fix1.out_valid", d0_out_valid, 0);

    // Backpressure: slot holds for 3 cycles, then pop and load on one edge.
    x_word = 32'hA5A5_0001;
    d0_in_valid = 4'b0010; d0_in_data[32 +: 32] = x_word; d0_out_ready = 1'b0;
    cyc(1);
    check("stall.load_chan", d0_out_chan, 1);
    d0_in_data[32 +: 32] = 32'h5A5A_0002;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall.in_ready", d0_in_ready, 0);
      check("stall.out_data", d0_out_data, x_word);
      cyc(1);
    end
    d0_out_ready = 1'b1;
    #1;
    check("stall.release_ready", d0_in_ready, 4'b0010);
    cyc(1);
    check("stall.reload_valid", d0_out_valid, 1);
    check("stall.reload_data", d0_out_data, 32'h5A5A_0002);
    d0_in_valid = 4'b0000;
    cyc(1);
    check("stall.drained", d0_out_valid, 0);

    // Round-robin over all-valid channels (pointer untouched by fixed transfers).
    d0_sel = 2'd0; d0_mode = 1'b1; d0_in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check($sformatf("rr.seq%0d", k), d0_out_chan, RR_EN ? (k % 4) : 0);
    end

    // Asynchronous reset mid-stream clears the slot before any edge.
    #2 reset = 1'b1;
    #1;
    check("areset.out_valid", d0_out_valid, 0);
    check("areset.out_data", d0_out_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1);
    check("areset.restart_chan", d0_out_chan, 0);
    check("areset.restart_valid", d0_out_valid, 1);

    // Random traffic on both instances, all modes and select values.
    for (int it = 0; it < 500; it++) begin
      d0_in_valid  = 4'($urandom);
      d0_sel       = 2'($urandom_range(0, 3));
      d0_mode      = 1'($urandom);
      d0_out_ready = ($urandom_range(0, 3) != 0);
      d0_in_data   = {$urandom, $urandom, $urandom, $urandom};
      d1_in_valid  = 3'($urandom);
      d1_sel       = 2'($urandom_range(0, 3));
      d1_mode      = 1'($urandom);
      d1_out_ready = ($urandom_range(0, 3) != 0);
      d1_in_data   = 24'($urandom);
      cyc(1);
    end

    // Drain: every accepted word must have come out.
    d0_in_valid = '0; d0_out_ready = 1'b1;
    d1_in_valid = '0; d1_out_ready = 1'b1;
    cyc(3);
    check("drain.u0_pending", sb0.size(), 0);
    check("drain.u1_pending", sb1.size(), 0);
    check("drain.u0_out_valid", d0_out_valid, 0);
    check("drain.u1_out_valid", d1_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ymux_arb.md
YMUX_ARB -- requirements
Module: ymux_arb

Interface
- REQ-001 SHALL have parameter SIZE, default 32, data width per channel in bits.
- REQ-002 SHALL have parameter N, default 4, number of input channels (2..16).
- REQ-003 SHALL have parameter SELW, default 2, select/channel-index width; N <= 2**SELW.
- REQ-004 SHALL have port clk, input, 1, single clock, rising-edge active.
- REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-006 SHALL have port in_data, input, N*SIZE, channel i at bits [i*SIZE +: SIZE].
- REQ-007 SHALL have port in_valid, input, N, per-channel valid.
- REQ-008 SHALL have port in_ready, output, N, per-channel ready (combinational).
- REQ-009 SHALL have port sel, input, SELW, channel index used in fixed mode.
- REQ-010 SHALL have port mode, input, 1, 0 = fixed select, 1 = round-robin.
- REQ-011 SHALL have port out_data, output, SIZE, registered selected data.
- REQ-012 SHALL have port out_chan, output, SELW, index of channel that supplied out_data.
- REQ-013 SHALL have port out_valid, output, 1, output register holds a word.
- REQ-014 SHALL have port out_ready, input, 1, downstream accepts word.

Function
- REQ-015 SHALL hold one output register; can_accept = !out_valid | out_ready.
- REQ-016 Fixed mode: grant channel sel iff sel < N and in_valid[sel]; sel >= N grants nothing.
- REQ-017 Round-robin mode: grant first valid channel at or after pointer ptr, scanning ascending, wrapping N-1 -> 0.
- REQ-018 in_ready[i] SHALL be 1 only for the granted channel and only when can_accept; all others 0.
- REQ-019 Transfer on channel i when in_valid[i] & in_ready[i]; next edge loads out_data, out_chan = i, out_valid = 1 (latency 1 cycle).
- REQ-020 Output pop (out_valid & out_ready) with no new transfer SHALL clear out_valid; simultaneous pop and transfer SHALL load new word, out_valid stays 1.
- REQ-021 While out_valid & !out_ready, out_data and out_chan SHALL hold stable and all in_ready SHALL be 0.
- REQ-022 After a round-robin transfer from channel g, ptr SHALL become g+1, wrapping N-1 -> 0; no transfer leaves ptr unchanged.
- REQ-023 Fixed-mode transfers SHALL NOT modify ptr; mode change takes effect the same cycle.
- REQ-024 No valid input: no transfer, output register unaffected except by pop.

Reset
- REQ-025 reset high SHALL asynchronously force out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
- REQ-026 During reset all in_ready SHALL be 0; a word held mid-handshake is discarded.
- REQ-027 First transfer possible on the first rising edge after reset deasserts.

Configuration
- REQ-028 Macro YMUX_ARB_RR_EN defined: round-robin logic and ptr compiled in, mode honoured per REQ-017/022.
- REQ-029 Macro undefined: no ptr register, mode input ignored, block behaves in fixed mode always.

Verification
- REQ-030 Fixed, sel=2, in_valid=4'b0100, ch2=32'hDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=DEADBEEF, out_chan=2.
- REQ-031 Fixed, sel=1, in_valid=4'b0001 -> in_ready=0000, out_valid stays 0.
- REQ-032 RR (macro on), in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
- REQ-033 out_valid=1, out_ready=0 for 3 cycles with new inputs valid -> out_data unchanged, in_ready=0000; out_ready=1 -> pop and load same edge.
- REQ-034 reset asserted mid-stream with out_valid=1 -> out_valid=0, out_data=0 immediately (before next clk edge); RR restarts at channel 0.
- REQ-035 Random 500-iteration run, all modes, SIZE=32/N=4 and SIZE=8/N=3 -> every accepted word appears once, in order, with correct out_chan; any mismatch prints FAIL.
